// File: rtl/muller_hs_pkg.sv
// +----------------------------------------------------------------------------+
// | muller_hs_pkg : shared types and defaults for the 4-phase handshake TX     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package muller_hs_pkg;

  localparam int unsigned c_WIDTH_DEF       = 4;
  localparam int unsigned c_SYNC_STAGES_DEF = 2;
  localparam int unsigned c_TIMEOUT_DEF     = 255;
  localparam int unsigned c_CNT_W           = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2,
    ERR  = 2'd3
  } hs_state_t;

  // Watchdog counter width; it only ever needs to hold TIMEOUT-1.
  function automatic int unsigned wd_width(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hs_sync.sv
// +----------------------------------------------------------------------------+
// | hs_sync : N-flop synchronizer for an asynchronous level, resets to 0       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module hs_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/muller_c_hs_tx.sv
// +----------------------------------------------------------------------------+
// | muller_c_hs_tx : valid/ready to 4-phase bundled-data transmitter           |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module muller_c_hs_tx
  import muller_hs_pkg::*;
#(
  parameter int unsigned WIDTH       = c_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES = c_SYNC_STAGES_DEF,
  parameter int unsigned TIMEOUT     = c_TIMEOUT_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               req_o,
  output logic [WIDTH-1:0]   data_o,
  input  logic               ack_i,
  input  logic               clear_i,
  output logic               busy,
  output logic               timeout_o,
  output logic [c_CNT_W-1:0] xfer_count
);

  localparam int unsigned        c_WD_W    = wd_width(TIMEOUT);
  localparam bit                 c_WD_EN   = (TIMEOUT != 0);
  localparam logic [c_WD_W-1:0]  c_WD_LAST = c_WD_W'(TIMEOUT - 1);

  hs_state_t           r_state;
  hs_state_t           w_next_state;
  logic                r_req;
  logic [WIDTH-1:0]    r_data;
  logic [c_WD_W-1:0]   r_wd;
  logic                r_timeout;
  logic [c_CNT_W-1:0]  r_count;
  logic                w_ack_s;
  logic                w_wd_hit;

  hs_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clock   (clock),
    .reset   (reset),
    .i_async (ack_i),
    .o_sync  (w_ack_s)
  );

  assign w_wd_hit = c_WD_EN && (r_wd == c_WD_LAST);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (in_valid) w_next_state = REQ;
      REQ: begin
        if (w_ack_s)       w_next_state = REL;
        else if (w_wd_hit) w_next_state = ERR;
      end
      REL: begin
        if (!w_ack_s)      w_next_state = IDLE;
        else if (w_wd_hit) w_next_state = ERR;
      end
      ERR: if (clear_i && !w_ack_s) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_data    <= '0;
      r_wd      <= '0;
      r_timeout <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_next_state;
      // req is high for exactly the REQ phase of the return-to-zero cycle
      r_req     <= (w_next_state == REQ);
      r_timeout <= (w_next_state == ERR);
      if (r_state == IDLE && in_valid) begin
        r_data <= in_data;
      end
      if (r_state == REL && !w_ack_s) begin
        r_count <= r_count + 1'b1;
      end
      if (w_next_state != r_state) begin
        r_wd <= '0;
      end else if (r_state == REQ || r_state == REL) begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

  assign in_ready   = (r_state == IDLE) && !reset;
  assign busy       = (r_state != IDLE);
  assign req_o      = r_req;
  assign data_o     = r_data;
  assign timeout_o  = r_timeout;
  assign xfer_count = r_count;

endmodule

`default_nettype wire
